score_display: RTL

Result-side consumer of the reaction-timer game controller. It accepts each measured reaction time, or a request to show the stored high score, over a valid/ready handshake. It tracks the best (lowest) time and converts the value to BCD with an iterative shift-add-3 sequencer. It drives the DE10-Lite seven-segment displays HEX0–HEX5 plus a new-record flag that the top level maps onto LEDR.

---
 rtl/score_pkg.sv | 20 ++
 rtl/score_display_seg7_enc.sv | 19 +
 rtl/score_display.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and seven-segment constants for the score display block.
// Segment bytes are active-low, bit order {dp,g,f,e,d,c,b,a}, dp always off.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHOW
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_H     = 8'h89;

  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

endpackage

// File: rtl/score_display_seg7_enc.sv
// BCD digit to active-low seven-segment encoder with a blanking input.
// Non-decimal codes render as blank.
module seg7_enc
  import score_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] seg
);

  // Table lookup, blank wins over the digit value
  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (bcd <= 4'd9)) begin
      seg = SEG_DIGIT[bcd];
    end
  end

endmodule

// File: rtl/score_display.sv
// Reaction-time result display: accepts results or high-score requests over
// valid/ready, tracks the lowest time, converts to BCD with an iterative
// shift-add-3 sequencer and drives HEX0..HEX5 plus a new-record flag.
// Optional build macro SCORE_LZ_BLANK_EN blanks leading-zero digits.
module score_display
  import score_pkg::*;
#(
  parameter int WIDTH  = 11,
  parameter int DIGITS = 4
) (
  input  logic             MAX10_CLK1_50,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_time,
  input  logic             in_hs_req,
  output logic [7:0]       HEX0,
  output logic [7:0]       HEX1,
  output logic [7:0]       HEX2,
  output logic [7:0]       HEX3,
  output logic [7:0]       HEX4,
  output logic [7:0]       HEX5,
  output logic             new_record,
  output logic             busy
);

  localparam int SR_W  = 4 * DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // The BCD field must be able to hold the largest binary value
  if (64'(10) ** DIGITS <= (64'(1) << WIDTH) - 64'd1) begin : g_digits_too_few
    $error("score_display: DIGITS too small for WIDTH");
  end

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  hiscore;
  logic              hs_valid;
  logic              hs_disp;
  logic              dash;
  logic              rdy;
  logic              busy_q;
  logic              nrec;
  logic [7:0]        hex_q [0:5];

  logic [3:0]        digit   [DIGITS];
  logic [7:0]        seg     [DIGITS];
  logic [DIGITS-1:0] blank_d;

  // One double-dabble step: correct every nibble >= 5, then shift left
  function automatic logic [SR_W-1:0] shift_add3(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[WIDTH + 4*i +: 4] >= 4'd5) begin
        r[WIDTH + 4*i +: 4] = r[WIDTH + 4*i +: 4] + 4'd3;
      end
    end
    return r << 1;
  endfunction

  // Slice the BCD field of the shift register into digits
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      digit[i] = sr[WIDTH + 4*i +: 4];
    end
  end

`ifdef SCORE_LZ_BLANK_EN
  logic lz_run;

  // Blank every zero digit above the most significant non-zero one; units always shown
  always_comb begin
    blank_d = '0;
    lz_run  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz_run     = lz_run && (digit[i] == 4'd0);
      blank_d[i] = lz_run;
    end
  end
`else
  assign blank_d = '0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_enc u_enc (
      .bcd   (digit[g]),
      .blank (blank_d[g]),
      .seg   (seg[g])
    );
  end

  // Handshake, high-score tracking, conversion sequencing and display load
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state    <= IDLE;
      rdy      <= 1'b0;
      busy_q   <= 1'b0;
      nrec     <= 1'b0;
      hiscore  <= '1;
      hs_valid <= 1'b0;
      hs_disp  <= 1'b0;
      dash     <= 1'b0;
      cnt      <= '0;
      for (int i = 0; i < 6; i++) begin
        hex_q[i] <= SEG_BLANK;
      end
    end else begin
      case (state)
        IDLE, SHOW: begin
          rdy    <= 1'b1;
          busy_q <= 1'b0;
          if (rdy && in_valid) begin
            rdy     <= 1'b0;
            busy_q  <= 1'b1;
            state   <= CONV;
            cnt     <= '0;
            hs_disp <= in_hs_req;
            dash    <= 1'b0;
            if (in_hs_req) begin
              sr   <= {{(4*DIGITS){1'b0}}, hiscore};
              dash <= !hs_valid;
            end else begin
              sr <= {{(4*DIGITS){1'b0}}, in_time};
              if (!hs_valid || (in_time < hiscore)) begin
                hiscore  <= in_time;
                hs_valid <= 1'b1;
                nrec     <= 1'b1;
              end else begin
                nrec <= 1'b0;
              end
            end
          end
        end
        CONV: begin
          if (dash || (cnt == CNT_W'(WIDTH))) begin
            for (int i = 0; i < 6; i++) begin
              hex_q[i] <= SEG_BLANK;
            end
            for (int i = 0; i < DIGITS; i++) begin
              hex_q[i] <= dash ? SEG_DASH : seg[i];
            end
            hex_q[5] <= hs_disp ? SEG_H : SEG_BLANK;
            state    <= SHOW;
            rdy      <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            sr  <= shift_add3(sr);
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = rdy;
  assign busy       = busy_q;
  assign new_record = nrec;
  assign HEX0       = hex_q[0];
  assign HEX1       = hex_q[1];
  assign HEX2       = hex_q[2];
  assign HEX3       = hex_q[3];
  assign HEX4       = hex_q[4];
  assign HEX5       = hex_q[5];

endmodule
